// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - EU result requests and CDB broadcast bundle for cdb_arbiter
// Payload layout, MSB first: {rob_idx, res_value, except_raised, except_code}.
interface cdb_arbiter_if #(
    parameter int EU_N      = 8,
    parameter int ROB_IDX_W = 5,
    parameter int XLEN      = 64,
    parameter int EXC_W     = 6
);
    localparam int CDB_W = ROB_IDX_W + XLEN + 1 + EXC_W;

    logic [EU_N-1:0]            eu_valid_i;
    logic [EU_N-1:0]            eu_ready_o;
    logic [EU_N-1:0][CDB_W-1:0] eu_data_i;
    logic                       rob_ready_i;
    logic                       cdb_valid_o;
    logic [CDB_W-1:0]           cdb_data_o;

    // master: execution units plus ROB side; slave: the arbiter itself
    modport master (
        output eu_valid_i,
        output eu_data_i,
        output rob_ready_i,
        input  eu_ready_o,
        input  cdb_valid_o,
        input  cdb_data_o
    );

    modport slave (
        input  eu_valid_i,
        input  eu_data_i,
        input  rob_ready_i,
        output eu_ready_o,
        output cdb_valid_o,
        output cdb_data_o
    );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - arbitrates EU results onto the single registered Common Data Bus
// LEN5_CDB_RR_ARB_EN selects round-robin search; when undefined, lowest EU index wins.
module cdb_arbiter #(
    parameter int EU_N      = 8,
    parameter int ROB_IDX_W = 5,
    parameter int XLEN      = 64,
    parameter int EXC_W     = 6
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           flush_i,
    cdb_arbiter_if.slave   bus
);
    localparam int CDB_W = ROB_IDX_W + XLEN + 1 + EXC_W;
    localparam int PTR_W = (EU_N > 1) ? $clog2(EU_N) : 1;

    logic             cdb_valid_q, cdb_valid_d;
    logic [CDB_W-1:0] cdb_data_q,  cdb_data_d;

    logic             slot_free;
    logic             grant_en;
    logic             grant_any;
    logic             grant_fire;
    logic [PTR_W-1:0] grant_idx;
    logic [EU_N-1:0]  grant_oh;

    // The output register may load whenever it is empty or being drained this cycle.
    assign slot_free  = !cdb_valid_q || bus.rob_ready_i;
    assign grant_en   = rst_ni && !flush_i && slot_free;
    assign grant_fire = grant_en && grant_any;

`ifdef LEN5_CDB_RR_ARB_EN
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W:0]   cand;

    // Search starts at ptr and wraps; cand is one bit wider so the sum cannot overflow.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < EU_N; k++) begin
            cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(EU_N)) begin
                cand = cand - (PTR_W+1)'(EU_N);
            end
            if (!grant_any && bus.eu_valid_i[cand[PTR_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (!flush_i && grant_fire) begin
            ptr_d = (grant_idx == PTR_W'(EU_N - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Descending scan so the lowest valid index is the last (and final) assignment.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = EU_N - 1; i >= 0; i--) begin
            if (bus.eu_valid_i[i]) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'(i);
            end
        end
    end
`endif

    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < EU_N; i++) begin
            grant_oh[i] = grant_fire && (grant_idx == PTR_W'(i));
        end
    end

    // Flush beats grant, grant beats drain; a drain and a grant in one cycle just reload.
    always_comb begin
        cdb_valid_d = cdb_valid_q;
        cdb_data_d  = cdb_data_q;
        if (flush_i) begin
            cdb_valid_d = 1'b0;
        end else if (grant_fire) begin
            cdb_valid_d = 1'b1;
            cdb_data_d  = bus.eu_data_i[grant_idx];
        end else if (cdb_valid_q && bus.rob_ready_i) begin
            cdb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cdb_valid_q <= 1'b0;
            cdb_data_q  <= '0;
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_data_q  <= cdb_data_d;
        end
    end

    assign bus.eu_ready_o  = grant_oh;
    assign bus.cdb_valid_o = cdb_valid_q;
    assign bus.cdb_data_o  = cdb_data_q;

    grant_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(bus.eu_ready_o));

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter (round-robin or fixed priority build)
module tb_cdb_arbiter;
    localparam int EU_N      = 8;
    localparam int ROB_IDX_W = 5;
    localparam int XLEN      = 64;
    localparam int EXC_W     = 6;
    localparam int CDB_W     = ROB_IDX_W + XLEN + 1 + EXC_W;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.EU_N(EU_N), .ROB_IDX_W(ROB_IDX_W), .XLEN(XLEN), .EXC_W(EXC_W)) bus ();

    cdb_arbiter #(.EU_N(EU_N), .ROB_IDX_W(ROB_IDX_W), .XLEN(XLEN), .EXC_W(EXC_W)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic             m_valid;
    logic [2:0]       m_ptr;
    logic [CDB_W-1:0] sb_q[$];
    int               dut_log[$];
    int               dut_cnt[EU_N];
    bit               auto_drop;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CDB_W-1:0] mk(input int idx, input logic [63:0] val);
        return {ROB_IDX_W'(idx), val, 1'b0, EXC_W'(idx)};
    endfunction

    function automatic int onehot_idx(input logic [EU_N-1:0] v);
        for (int i = 0; i < EU_N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [EU_N-1:0] exp_grant(input logic [EU_N-1:0] v, input logic [2:0] p,
                                                  input bit en);
        logic [EU_N-1:0] one;
        one = 1;
        if (!en) return '0;
`ifdef LEN5_CDB_RR_ARB_EN
        for (int k = 0; k < EU_N; k++) begin
            int j;
            j = (int'(p) + k) % EU_N;
            if (v[j]) return one << j;
        end
`else
        for (int j = 0; j < EU_N; j++) if (v[j]) return one << j;
`endif
        return '0;
    endfunction

    function automatic logic [ROB_IDX_W-1:0] rob_idx_of(input logic [CDB_W-1:0] d);
        return d[CDB_W-1 -: ROB_IDX_W];
    endfunction

    // One clock: sample and compare at negedge, advance the model, then apply EU drops.
    task automatic cycle(input string tag);
        logic [EU_N-1:0] v, eg, obs;
        logic            rr, fl;
        int              g, og;
        @(negedge clk);
        v   = bus.eu_valid_i;
        rr  = bus.rob_ready_i;
        fl  = flush;
        obs = bus.eu_ready_o;
        eg  = exp_grant(v, m_ptr, !fl && (!m_valid || rr));
        check($sformatf("%s.eu_ready", tag), obs, eg);
        check($sformatf("%s.cdb_valid", tag), bus.cdb_valid_o, m_valid);
        if (m_valid && sb_q.size() > 0) begin
            check($sformatf("%s.cdb_data", tag), bus.cdb_data_o, sb_q[0]);
            if (fl || rr) sb_q.delete(0);
        end
        og = onehot_idx(obs);
        if (og >= 0) begin
            dut_cnt[og]++;
            dut_log.push_back(og);
        end
        g = onehot_idx(eg);
        if (fl) begin
            m_valid = 1'b0;
        end else if (g >= 0) begin
            sb_q.push_back(bus.eu_data_i[g]);
            m_valid = 1'b1;
            m_ptr   = 3'((g + 1) % EU_N);
        end else if (m_valid && rr) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        if (auto_drop) bus.eu_valid_i = bus.eu_valid_i & ~(obs & v);
    endtask

    task automatic clear_logs();
        dut_log.delete();
        foreach (dut_cnt[i]) dut_cnt[i] = 0;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        flush           = 1'b0;
        bus.eu_valid_i  = '0;
        bus.eu_data_i   = '0;
        bus.rob_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.cdb_valid", bus.cdb_valid_o, 1'b0);
        check("rst.cdb_data", bus.cdb_data_o, '0);
        bus.eu_valid_i = '1;
        #1;
        check("rst.eu_ready", bus.eu_ready_o, '0);
        bus.eu_valid_i = '0;
        @(negedge clk);
        rst_n   = 1'b1;
        m_valid = 1'b0;
        m_ptr   = '0;
        sb_q.delete();
        clear_logs();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [95:0] r;
        bit          fl_prev;
        auto_drop = 1'b1;

        // single request, one-cycle latency, then drain
        do_reset();
        bus.eu_data_i[2] = mk(5, 64'h1234);
        bus.eu_valid_i   = 8'b0000_0100;
        cycle("single.req");
        check("single.lat_valid", bus.cdb_valid_o, 1'b1);
        check("single.lat_idx", rob_idx_of(bus.cdb_data_o), 5'd5);
        cycle("single.bcast");
        check("single.drained", bus.cdb_valid_o, 1'b0);

        // grant order with each EU dropping after accept, then wrap to 0
        do_reset();
        bus.eu_data_i[0] = mk(1, 64'hA0);
        bus.eu_data_i[1] = mk(2, 64'hA1);
        bus.eu_data_i[7] = mk(8, 64'hA7);
        bus.eu_valid_i   = 8'b1000_0011;
        repeat (3) cycle("order");
        check("order.count", dut_log.size(), 3);
        if (dut_log.size() >= 3) begin
            check("order.g0", dut_log[0], 0);
            check("order.g1", dut_log[1], 1);
            check("order.g2", dut_log[2], 7);
        end
        clear_logs();
        bus.eu_valid_i = 8'b1111_1111;
        cycle("order.wrap");
        bus.eu_valid_i = '0;
        check("order.wrap_g", dut_log.size() > 0 ? dut_log[0] : -1, 0);
        cycle("order.idle");

        // backpressure holds payload and blocks grants
        do_reset();
        bus.eu_data_i[0] = mk(3, 64'hB0);
        bus.eu_valid_i   = 8'b0000_0001;
        cycle("bp.fill");
        bus.rob_ready_i  = 1'b0;
        bus.eu_data_i[2] = mk(9, 64'hB2);
        bus.eu_valid_i   = 8'b0000_0100;
        for (int i = 0; i < 4; i++) begin
            #1 check("bp.ready_low", bus.eu_ready_o, '0);
            cycle("bp.hold");
            check("bp.idx_steady", rob_idx_of(bus.cdb_data_o), 5'd3);
        end
        bus.rob_ready_i = 1'b1;
        #1 check("bp.release_ready", bus.eu_ready_o, 8'b0000_0100);
        cycle("bp.release");
        check("bp.new_idx", rob_idx_of(bus.cdb_data_o), 5'd9);
        cycle("bp.drain");

        // flush while FULL and stalled; pointer must survive the flush
        do_reset();
        auto_drop        = 1'b0;
        bus.eu_data_i[1] = mk(11, 64'hC1);
        bus.eu_valid_i   = 8'b0000_0010;
        cycle("fl.fill");
        bus.rob_ready_i  = 1'b0;
        bus.eu_data_i[0] = mk(12, 64'hC0);
        bus.eu_data_i[7] = mk(13, 64'hC7);
        bus.eu_valid_i   = 8'b1000_0001;
        cycle("fl.stall");
        flush = 1'b1;
        #1 check("fl.ready_low", bus.eu_ready_o, '0);
        cycle("fl.flush");
        flush = 1'b0;
        check("fl.killed", bus.cdb_valid_o, 1'b0);
        clear_logs();
        cycle("fl.after");
`ifdef LEN5_CDB_RR_ARB_EN
        check("fl.ptr_kept", dut_log.size() > 0 ? dut_log[0] : -1, 7);
`else
        check("fl.ptr_kept", dut_log.size() > 0 ? dut_log[0] : -1, 0);
`endif
        bus.eu_valid_i  = '0;
        bus.rob_ready_i = 1'b1;
        cycle("fl.drain");

        // fairness: everybody requesting for 16 back-to-back cycles
        do_reset();
        auto_drop = 1'b0;
        for (int i = 0; i < EU_N; i++) bus.eu_data_i[i] = mk(16 + i, 64'(i));
        bus.eu_valid_i = '1;
        clear_logs();
        for (int c = 0; c < 16; c++) cycle("fair");
        for (int i = 0; i < EU_N; i++) begin
`ifdef LEN5_CDB_RR_ARB_EN
            check($sformatf("fair.cnt%0d", i), dut_cnt[i], 2);
`else
            check($sformatf("fair.cnt%0d", i), dut_cnt[i], (i == 0) ? 16 : 0);
`endif
        end
        bus.eu_valid_i = '0;
        cycle("fair.drain");

        // random traffic: EUs hold until accepted, drop everything on flush
        do_reset();
        auto_drop = 1'b1;
        fl_prev   = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (fl_prev) bus.eu_valid_i = '0;
            for (int i = 0; i < EU_N; i++) begin
                if (!bus.eu_valid_i[i] && $urandom_range(0, 2) == 0) begin
                    r = {$urandom, $urandom, $urandom};
                    bus.eu_data_i[i]  = r[CDB_W-1:0];
                    bus.eu_valid_i[i] = 1'b1;
                end
            end
            bus.rob_ready_i = ($urandom_range(0, 3) != 0);
            flush           = ($urandom_range(0, 19) == 0);
            fl_prev         = flush;
            cycle("rand");
        end
        flush = 1'b0;

        // async reset mid-cycle while FULL, then restart from index 0
        do_reset();
        bus.rob_ready_i  = 1'b0;
        bus.eu_data_i[3] = mk(21, 64'hD3);
        bus.eu_valid_i   = 8'b0000_1000;
        cycle("ar.fill");
        bus.eu_valid_i = '0;
        check("ar.full", bus.cdb_valid_o, 1'b1);
        #2 rst_n = 1'b0;
        #1 check("ar.async_clear", bus.cdb_valid_o, 1'b0);
        @(negedge clk);
        rst_n   = 1'b1;
        m_valid = 1'b0;
        m_ptr   = '0;
        sb_q.delete();
        clear_logs();
        @(posedge clk);
        #1;
        bus.rob_ready_i  = 1'b1;
        bus.eu_data_i[0] = mk(22, 64'hE0);
        bus.eu_data_i[4] = mk(23, 64'hE4);
        bus.eu_data_i[7] = mk(24, 64'hE7);
        bus.eu_valid_i   = 8'b1001_0001;
        cycle("ar.first");
        check("ar.first_g", dut_log.size() > 0 ? dut_log[0] : -1, 0);
        bus.eu_valid_i = '0;
        cycle("ar.drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
